// File: rtl/audio_mode_ctrl_if.sv
// Signal bundle between the record/playback sequencer (slave) and the board,
// codec and RAM bridge around it (master).
interface audio_mode_ctrl_if #(
   parameter int ADDR_W = 26
) ();
   logic              key_rec_n;
   logic              key_play_n;
   logic              key_stop_n;
   logic              loop_en;
   logic              s_end;
   logic              s_req;
   logic              rdy;
   logic [ADDR_W-1:0] max_ram_address;
   logic              write;
   logic              read;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] rec_length;
   logic [1:0]        mode;
   logic              overflow;
   logic [7:0]        drop_count;

   modport master (
      output key_rec_n, key_play_n, key_stop_n, loop_en, s_end, s_req, rdy,
             max_ram_address,
      input  write, read, address, rec_length, mode, overflow, drop_count
   );

   modport slave (
      input  key_rec_n, key_play_n, key_stop_n, loop_en, s_end, s_req, rdy,
             max_ram_address,
      output write, read, address, rec_length, mode, overflow, drop_count
   );
endinterface

// File: rtl/audio_mode_ctrl.sv
// Record/playback sequencer: debounces board keys, turns codec sample strobes
// into one-cycle write/read commands, and owns the sample address / length.
module audio_mode_ctrl #(
   parameter int ADDR_W          = 26,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic              clk,
   input logic              reset,
   audio_mode_ctrl_if.slave bus
);
   localparam logic [1:0] MODE_IDLE   = 2'd0;
   localparam logic [1:0] MODE_RECORD = 2'd1;
   localparam logic [1:0] MODE_PLAY   = 2'd2;

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam int KEY_REC  = 0;
   localparam int KEY_PLAY = 1;
   localparam int KEY_STOP = 2;

   logic [2:0] key_raw;
   logic [2:0] press;
   logic [1:0] strobe_raw;
   logic [1:0] strobe_evt;

   assign key_raw    = {bus.key_stop_n, bus.key_play_n, bus.key_rec_n};
   assign strobe_raw = {bus.s_req, bus.s_end};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_key
         logic [1:0]       sync_reg;
         logic             stable_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             press_reg;

         // Synchronizers start at the released level so reset never looks like a press.
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_reg   <= 2'b11;
               stable_reg <= 1'b1;
               cnt_reg    <= '0;
               press_reg  <= 1'b0;
            end else begin
               sync_reg  <= {sync_reg[0], key_raw[gi]};
               press_reg <= 1'b0;
               if (sync_reg[1] == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  cnt_reg    <= '0;
                  stable_reg <= sync_reg[1];
                  press_reg  <= ~sync_reg[1];
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign press[gi] = press_reg;
      end

      for (gi = 0; gi < 2; gi++) begin : g_strobe
         logic [2:0] sync_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[1:0], strobe_raw[gi]};
            end
         end

         assign strobe_evt[gi] = sync_reg[1] & ~sync_reg[2];
      end
   endgenerate

   logic              press_stop;
   logic              start_rec;
   logic              start_play;
   logic              end_evt;
   logic              req_evt;
   logic [1:0]        mode_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [ADDR_W-1:0] rec_length_reg;
   logic              overflow_reg;
   logic              write_reg;
   logic              read_reg;
   logic [7:0]        drop_reg;
   logic [ADDR_W-1:0] address_next;

   assign press_stop   = press[KEY_STOP];
   assign start_rec    = press[KEY_REC] & ~press[KEY_STOP];
   assign start_play   = press[KEY_PLAY] & ~press[KEY_REC] & ~press[KEY_STOP];
   assign end_evt      = strobe_evt[0];
   assign req_evt      = strobe_evt[1];
   assign address_next = address_reg + 1'b1;

   // The address advances in the cycle after a write/read pulse, so the pulse
   // always carries the slot it refers to. Two strobe events are never adjacent.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_reg       <= MODE_IDLE;
         address_reg    <= '0;
         rec_length_reg <= '0;
         overflow_reg   <= 1'b0;
         write_reg      <= 1'b0;
         read_reg       <= 1'b0;
         drop_reg       <= '0;
      end else begin
         write_reg <= 1'b0;
         read_reg  <= 1'b0;
         case (mode_reg)
            MODE_IDLE: begin
               if (start_rec) begin
                  mode_reg       <= MODE_RECORD;
                  address_reg    <= '0;
                  rec_length_reg <= '0;
                  overflow_reg   <= 1'b0;
                  drop_reg       <= '0;
               end else if (start_play && rec_length_reg != '0) begin
                  mode_reg    <= MODE_PLAY;
                  address_reg <= '0;
               end
            end

            MODE_RECORD: begin
               if (press_stop) begin
                  mode_reg <= MODE_IDLE;
                  if (write_reg) begin
                     address_reg    <= address_next;
                     rec_length_reg <= address_next;
                  end
               end else if (start_rec) begin
                  address_reg    <= '0;
                  rec_length_reg <= '0;
                  overflow_reg   <= 1'b0;
                  drop_reg       <= '0;
               end else if (write_reg) begin
                  address_reg    <= address_next;
                  rec_length_reg <= address_next;
                  if (address_next >= bus.max_ram_address) begin
                     overflow_reg <= 1'b1;
                     mode_reg     <= MODE_IDLE;
                  end
               end else if (end_evt) begin
                  if (bus.rdy) begin
                     write_reg <= 1'b1;
                  end else if (drop_reg != 8'hFF) begin
                     drop_reg <= drop_reg + 1'b1;
                  end
               end
            end

            MODE_PLAY: begin
               if (press_stop) begin
                  mode_reg    <= MODE_IDLE;
                  address_reg <= '0;
               end else if (start_rec) begin
                  mode_reg       <= MODE_RECORD;
                  address_reg    <= '0;
                  rec_length_reg <= '0;
                  overflow_reg   <= 1'b0;
                  drop_reg       <= '0;
               end else if (start_play) begin
                  address_reg <= '0;
               end else if (read_reg) begin
                  if (address_next >= rec_length_reg) begin
                     address_reg <= '0;
                     if (!bus.loop_en) begin
                        mode_reg <= MODE_IDLE;
                     end
                  end else begin
                     address_reg <= address_next;
                  end
               end else if (req_evt) begin
                  if (bus.rdy) begin
                     read_reg <= 1'b1;
                  end else if (drop_reg != 8'hFF) begin
                     drop_reg <= drop_reg + 1'b1;
                  end
               end
            end

            default: begin
               mode_reg <= MODE_IDLE;
            end
         endcase
      end
   end

   assign bus.write      = write_reg;
   assign bus.read       = read_reg;
   assign bus.address    = address_reg;
   assign bus.rec_length = rec_length_reg;
   assign bus.mode       = mode_reg;
   assign bus.overflow   = overflow_reg;
   assign bus.drop_count = drop_reg;
endmodule

// File: tb/tb_audio_mode_ctrl.sv
// Bench for audio_mode_ctrl: directed vector table, hand-written corner
// sequences, and random operations checked against a sample-level model.
module tb_audio_mode_ctrl;
   localparam int ADDR_W  = 8;
   localparam int DEB     = 4;
   localparam int OP_REC  = 0;
   localparam int OP_PLAY = 1;
   localparam int OP_STOP = 2;
   localparam int OP_END  = 3;
   localparam int OP_REQ  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   overlap = 0;

   audio_mode_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   audio_mode_ctrl #(.ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int op;
      bit rdy;
      bit loop;
      int wr;
      int rd;
      int paddr;
      int mode;
      int addr;
      int len;
      int ovf;
      int drop;
   } vec_t;

   vec_t vecs[$];

   // Sample-level reference model state
   int m_mode, m_addr, m_len, m_ovf, m_drop, m_max;

   function automatic void add(int op, bit rdy, bit loop, int wr, int rd, int paddr,
                               int mode, int addr, int len, int ovf, int drop);
      vec_t v;
      v.op = op; v.rdy = rdy; v.loop = loop; v.wr = wr; v.rd = rd; v.paddr = paddr;
      v.mode = mode; v.addr = addr; v.len = len; v.ovf = ovf; v.drop = drop;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_state(string tag, int mode, int addr, int len, int ovf, int drop);
      check({tag, ".mode"}, int'(bus.mode), mode);
      check({tag, ".address"}, int'(bus.address), addr);
      check({tag, ".rec_length"}, int'(bus.rec_length), len);
      check({tag, ".overflow"}, int'(bus.overflow), ovf);
      check({tag, ".drop_count"}, int'(bus.drop_count), drop);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   // mask bit0=rec, bit1=play, bit2=stop; all selected keys go down together
   task automatic press_key(int mask);
      if (mask[0]) bus.key_rec_n = 1'b0;
      if (mask[1]) bus.key_play_n = 1'b0;
      if (mask[2]) bus.key_stop_n = 1'b0;
      repeat (12) tick();
      bus.key_rec_n  = 1'b1;
      bus.key_play_n = 1'b1;
      bus.key_stop_n = 1'b1;
      repeat (12) tick();
   endtask

   task automatic strobe(int op, bit r, output int nwr, output int nrd,
                         output int paddr, output int lat);
      nwr = 0; nrd = 0; paddr = -1; lat = -1;
      bus.rdy = r;
      if (op == OP_END) bus.s_end = 1'b1;
      else bus.s_req = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 2) begin
            bus.s_end = 1'b0;
            bus.s_req = 1'b0;
         end
         if ((bus.write || bus.read) && lat < 0) begin
            lat   = t;
            paddr = int'(bus.address);
         end
         if (bus.write) nwr++;
         if (bus.read) nrd++;
         if (bus.write && bus.read) overlap++;
      end
      bus.rdy = 1'b1;
   endtask

   task automatic apply(int op, bit r, bit lp, output int nwr, output int nrd,
                        output int paddr, output int lat);
      bus.loop_en = lp;
      nwr = 0; nrd = 0; paddr = -1; lat = -1;
      case (op)
         OP_REC:  press_key(1);
         OP_PLAY: press_key(2);
         OP_STOP: press_key(4);
         default: strobe(op, r, nwr, nrd, paddr, lat);
      endcase
   endtask

   task automatic check_pulse(string tag, int nwr, int nrd, int paddr, int lat,
                              int ewr, int erd, int epaddr);
      check({tag, ".writes"}, nwr, ewr);
      check({tag, ".reads"}, nrd, erd);
      if (ewr + erd > 0) begin
         check({tag, ".pulse_addr"}, paddr, epaddr);
         check({tag, ".latency"}, lat, 3);
      end
   endtask

   // Reference behaviour expressed per whole operation (one key press or one sample strobe)
   task automatic model_step(int op, bit r, bit lp, output int ewr, output int erd,
                             output int epaddr);
      ewr = 0; erd = 0; epaddr = -1;
      case (op)
         OP_REC: begin
            m_mode = 1; m_addr = 0; m_len = 0; m_ovf = 0; m_drop = 0;
         end
         OP_PLAY: begin
            if ((m_mode == 0 && m_len != 0) || m_mode == 2) begin
               m_mode = 2; m_addr = 0;
            end
         end
         OP_STOP: begin
            if (m_mode == 2) m_addr = 0;
            m_mode = 0;
         end
         OP_END: begin
            if (m_mode == 1) begin
               if (r) begin
                  ewr = 1; epaddr = m_addr;
                  m_addr = m_addr + 1;
                  m_len = m_addr;
                  if (m_addr >= m_max) begin
                     m_ovf = 1; m_mode = 0;
                  end
               end else if (m_drop < 255) begin
                  m_drop++;
               end
            end
         end
         default: begin
            if (m_mode == 2) begin
               if (r) begin
                  erd = 1; epaddr = m_addr;
                  m_addr = m_addr + 1;
                  if (m_addr >= m_len) begin
                     m_addr = 0;
                     if (!lp) m_mode = 0;
                  end
               end else if (m_drop < 255) begin
                  m_drop++;
               end
            end
         end
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int nwr, nrd, paddr, lat, ewr, erd, epaddr, waited;
      bit found;

      bus.key_rec_n = 1'b1; bus.key_play_n = 1'b1; bus.key_stop_n = 1'b1;
      bus.loop_en = 1'b0; bus.s_end = 1'b0; bus.s_req = 1'b0; bus.rdy = 1'b1;
      bus.max_ram_address = ADDR_W'(200);

      // --- reset state ---
      repeat (3) tick();
      check("rst.write", int'(bus.write), 0);
      check("rst.read", int'(bus.read), 0);
      check_state("rst", 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();

      // --- debounce: short bounces never press, the long hold presses once ---
      for (int i = 0; i < 3; i++) begin
         bus.key_rec_n = 1'b0; tick();
         bus.key_rec_n = 1'b1; tick();
      end
      repeat (8) tick();
      check("deb.bounce_mode", int'(bus.mode), 0);
      bus.key_rec_n = 1'b0;
      found = 1'b0; waited = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         tick();
         if (bus.mode == 2'd1) begin
            found = 1'b1; waited = i;
         end
      end
      check("deb.press_seen", int'(found), 1);
      check("deb.not_early", int'(waited >= 6), 1);
      strobe(OP_END, 1'b1, nwr, nrd, paddr, lat);
      check_pulse("deb.write", nwr, nrd, paddr, lat, 1, 0, 0);
      repeat (10) tick();
      check("deb.single_press_addr", int'(bus.address), 1);
      bus.key_rec_n = 1'b1;
      repeat (12) tick();
      check("deb.after_release", int'(bus.mode), 1);

      // --- directed vector table ---
      do_reset();
      add(OP_PLAY, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(OP_REC,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) add(OP_END, 1, 0, 1, 0, k, 1, k + 1, k + 1, 0, 0);
      add(OP_PLAY, 1, 0, 0, 0, 0, 1, 5, 5, 0, 0);
      add(OP_STOP, 1, 0, 0, 0, 0, 0, 5, 5, 0, 0);
      add(OP_END,  1, 0, 0, 0, 0, 0, 5, 5, 0, 0);
      add(OP_REC,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) add(OP_END, 1, 0, 1, 0, k, 1, k + 1, k + 1, 0, 0);
      add(OP_STOP, 1, 0, 0, 0, 0, 0, 3, 3, 0, 0);
      add(OP_PLAY, 1, 0, 0, 0, 0, 2, 0, 3, 0, 0);
      add(OP_REQ,  1, 0, 0, 1, 0, 2, 1, 3, 0, 0);
      add(OP_REQ,  1, 0, 0, 1, 1, 2, 2, 3, 0, 0);
      add(OP_REQ,  1, 0, 0, 1, 2, 0, 0, 3, 0, 0);
      add(OP_REQ,  1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      add(OP_PLAY, 1, 1, 0, 0, 0, 2, 0, 3, 0, 0);
      for (int k = 0; k < 7; k++) add(OP_REQ, 1, 1, 0, 1, k % 3, 2, (k + 1) % 3, 3, 0, 0);
      add(OP_END,  1, 1, 0, 0, 0, 2, 1, 3, 0, 0);
      add(OP_REQ,  0, 1, 0, 0, 0, 2, 1, 3, 0, 1);
      add(OP_PLAY, 1, 1, 0, 0, 0, 2, 0, 3, 0, 1);
      add(OP_REC,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      add(OP_END,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      add(OP_END,  1, 0, 1, 0, 0, 1, 1, 1, 0, 1);
      add(OP_REQ,  1, 0, 0, 0, 0, 1, 1, 1, 0, 1);
      add(OP_STOP, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         apply(vecs[i].op, vecs[i].rdy, vecs[i].loop, nwr, nrd, paddr, lat);
         check_pulse(tag, nwr, nrd, paddr, lat, vecs[i].wr, vecs[i].rd, vecs[i].paddr);
         check_state(tag, vecs[i].mode, vecs[i].addr, vecs[i].len, vecs[i].ovf, vecs[i].drop);
      end

      // --- capacity overflow at max_ram_address=4 ---
      bus.max_ram_address = ADDR_W'(4);
      press_key(1);
      for (int i = 0; i < 6; i++) begin
         strobe(OP_END, 1'b1, nwr, nrd, paddr, lat);
         check_pulse($sformatf("ovf%0d", i), nwr, nrd, paddr, lat, (i < 4) ? 1 : 0, 0, i);
      end
      check_state("ovf.final", 0, 4, 4, 1, 0);

      // --- reset in the middle of playback ---
      press_key(2);
      strobe(OP_REQ, 1'b1, nwr, nrd, paddr, lat);
      strobe(OP_REQ, 1'b1, nwr, nrd, paddr, lat);
      check_state("play_mid", 2, 2, 4, 1, 0);
      reset = 1'b1;
      tick();
      check_state("rst_play", 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();

      // --- simultaneous key presses ---
      bus.max_ram_address = ADDR_W'(200);
      press_key(5);
      check("stop_rec.mode", int'(bus.mode), 0);
      press_key(3);
      check("rec_play.mode", int'(bus.mode), 1);
      press_key(4);
      check("stop.mode", int'(bus.mode), 0);

      // --- random operations against the model ---
      do_reset();
      m_mode = 0; m_addr = 0; m_len = 0; m_ovf = 0; m_drop = 0;
      m_max = int'($urandom_range(3, 10));
      bus.max_ram_address = ADDR_W'(m_max);
      for (int i = 0; i < 80; i++) begin
         int sel, op;
         bit r, lp;
         string tag;
         sel = int'($urandom_range(0, 99));
         op = (sel < 8) ? OP_REC : (sel < 16) ? OP_PLAY : (sel < 21) ? OP_STOP :
              (sel < 60) ? OP_END : OP_REQ;
         r  = ($urandom_range(0, 4) != 0);
         lp = 1'($urandom_range(0, 1));
         tag = $sformatf("rnd%0d", i);
         model_step(op, r, lp, ewr, erd, epaddr);
         apply(op, r, lp, nwr, nrd, paddr, lat);
         check_pulse(tag, nwr, nrd, paddr, lat, ewr, erd, epaddr);
         check_state(tag, m_mode, m_addr, m_len, m_ovf, m_drop);
      end

      check("write_read_overlap", overlap, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_mode_ctrl.md
Name: audio_mode_ctrl

Overview:
- Record/playback sequencer that sits directly upstream of the audio/RAM bridge controller.
- Turns raw board keys and codec sample strobes into the bridge's one-cycle write/read commands.
- Owns the RAM sample address counter and the recorded-length register.
- Handles debounce, mode sequencing, end-of-recording/playback wrap, and drop accounting when RAM is not ready.

Parameters:
- ADDR_W, 26, width of the RAM sample address.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a key press is accepted (benches override to 4).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_rec_n  input  1  raw record key, active-low, asynchronous
- key_play_n  input  1  raw play key, active-low, asynchronous
- key_stop_n  input  1  raw stop key, active-low, asynchronous
- loop_en  input  1  playback wraps to 0 at end when high
- s_end  input  1  ADC sample-complete strobe from codec (asynchronous level)
- s_req  input  1  DAC sample-request strobe from codec (asynchronous level)
- rdy  input  1  RAM interface ready
- max_ram_address  input  ADDR_W  capacity; slots 0..max_ram_address-1 are usable
- write  output  1  one-cycle write command to bridge
- read  output  1  one-cycle read command to bridge
- address  output  ADDR_W  sample slot for the current write/read pulse
- rec_length  output  ADDR_W  number of samples recorded
- mode  output  2  0=IDLE, 1=RECORD, 2=PLAY
- overflow  output  1  recording stopped on capacity
- drop_count  output  8  strobes lost because rdy=0, saturating at 255

Behaviour:
- Reset: all outputs 0; mode=IDLE; synchronizers and debounce counters cleared. Reset mid-operation aborts any mode at once and clears rec_length.
- Keys:
  - 2-FF synchronizer per key, then a debounce counter per key.
  - The counter reloads whenever the synced level changes.
  - When the level has been low for DEBOUNCE_CYCLES consecutive cycles, exactly one press pulse is emitted.
  - No further pulse until the level is released (high for DEBOUNCE_CYCLES) and pressed again.
  - Same-cycle presses: stop > rec > play; lower-priority pulses that cycle are discarded.
- Strobes:
  - s_end and s_req each pass through a 2-FF synchronizer and a rising-edge detector.
  - An edge event occurs in the cycle after the second flop goes high: a fixed 3-cycle latency from input rise to write/read pulse.
- IDLE:
  - rec press -> RECORD; address<=0, rec_length<=0, overflow<=0, drop_count<=0.
  - play press with rec_length!=0 -> PLAY; address<=0.
  - play press with rec_length==0 is ignored.
  - Strobes are ignored.
- RECORD:
  - s_end edge with rdy=1: write=1 for one cycle with the current address; next cycle address<=address+1 and rec_length<=address+1.
  - s_end edge with rdy=0: no write, address unchanged, drop_count+1 (saturating).
  - After an increment, if address==max_ram_address: overflow<=1, mode->IDLE, address holds.
  - stop -> IDLE, rec_length kept.
  - rec press -> restart recording from 0.
  - play press ignored.
- PLAY:
  - s_req edge with rdy=1: read=1 for one cycle with the current address; then address+1.
  - s_req edge with rdy=0: drop_count+1, no read.
  - When the incremented address equals rec_length: loop_en=1 -> address<=0, stay in PLAY; loop_en=0 -> IDLE, address<=0.
  - stop -> IDLE.
  - rec press -> RECORD (same init as from IDLE).
  - play press restarts at address 0.
- A key press in the same cycle as a strobe edge: the mode change wins, and the strobe is not serviced.
- write and read are never high together. Neither pulses outside its mode.
- mode is registered and reflects the new state one cycle after the press pulse.

Test Plan:
- DEBOUNCE_CYCLES=4; key_rec_n bounces low/high 3 cycles, then is held low 10 cycles -> exactly one press, mode=1 once the hold is debounced; no press during bouncing.
- RECORD, rdy=1, 5 s_end pulses -> 5 write pulses, each 3 cycles after its rise, at addresses 0..4; rec_length=5; stop -> mode=0, rec_length stays 5.
- rec_length=3, loop_en=0, play, 4 s_req pulses -> reads at addresses 0, 1, 2, then mode=0 after the third read; 4th strobe produces no read.
- Same as previous with loop_en=1, 7 s_req pulses -> read addresses 0, 1, 2, 0, 1, 2, 0; mode stays 2.
- max_ram_address=4, RECORD, 6 s_end pulses -> writes at addresses 0..3, overflow=1, mode=0, rec_length=4; rdy=0 on a strobe while recording -> drop_count increments, address unchanged.
- Reset asserted during PLAY at address 2 -> next cycle mode=0, address=0, rec_length=0; stop and rec pressed in the same cycle in IDLE -> stays IDLE.
